// File: rtl/rggen_bit_field_rwl_rwe_keyed_if.sv
// Shared lock/enable mode package and the register-side interface
// that a bit field drives its slice of.
package rggen_rtl_pkg;
    typedef enum logic {
        RGGEN_LOCK_MODE,
        RGGEN_ENABLE_MODE
    } rggen_rwle_mode;
endpackage

interface rggen_register_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  write;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] value;

    function automatic logic write_access();
        return valid && write;
    endfunction

    modport host (
        output valid,
        output write,
        output write_data,
        output write_mask,
        input  read_data,
        input  value,
        import write_access
    );

    modport data (
        input  valid,
        input  write,
        input  write_data,
        input  write_mask,
        output read_data,
        output value,
        import write_access
    );
endinterface

// File: rtl/rggen_bit_field_rwl_rwe_keyed.sv
// Lock/enable gated bit field whose write window is opened by a
// two-word key sequence, with optional relock after one write.
module rggen_bit_field_rwl_rwe_keyed
    import rggen_rtl_pkg::*;
#(
    parameter rggen_rwle_mode         MODE          = RGGEN_LOCK_MODE,
    parameter int                     MSB           = 0,
    parameter int                     LSB           = 0,
    parameter logic [MSB-LSB:0]       INITIAL_VALUE = '0,
    parameter bit                     USE_KEY       = 1'b1,
    parameter int                     KEY_WIDTH     = 8,
    parameter logic [KEY_WIDTH-1:0]   KEY0          = 'h5A,
    parameter logic [KEY_WIDTH-1:0]   KEY1          = 'hA5,
    parameter int                     WINDOW        = 16,
    parameter bit                     LOCK_ON_WRITE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_lock_or_enable,
    input  logic                 i_key_valid,
    input  logic [KEY_WIDTH-1:0] i_key_data,
    rggen_register_if.data       register_if,
    output logic [MSB-LSB:0]     o_value,
    output logic                 o_unlocked,
    output logic                 o_violation
);
    localparam int W  = MSB - LSB + 1;
    localparam int CW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        LOCKED,
        KEY0_SEEN,
        OPEN
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          unlocked;
    logic [W-1:0]  value;
    logic          violation;

    logic          gate_ok;
    logic          wr;
    logic          is_open;
    logic          accept;
    logic [W-1:0]  wdata;
    logic [W-1:0]  wmask;

    always_comb begin
        gate_ok = (MODE == RGGEN_LOCK_MODE) ? !i_lock_or_enable
                                            : i_lock_or_enable;
        wr      = register_if.write_access();
        is_open = USE_KEY ? (state == OPEN) : 1'b1;
        accept  = wr && gate_ok && is_open;
        wdata   = register_if.write_data[MSB:LSB];
        wmask   = register_if.write_mask[MSB:LSB];
    end

    // KEY1 is tested before KEY0 so a repeated KEY0 keeps waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOCKED;
            count    <= '0;
            unlocked <= 1'b0;
        end else begin
            unique case (state)
                LOCKED: begin
                    if (i_key_valid && (i_key_data == KEY0)) begin
                        state <= KEY0_SEEN;
                    end
                end
                KEY0_SEEN: begin
                    if (i_key_valid) begin
                        if (i_key_data == KEY1) begin
                            state    <= OPEN;
                            count    <= CW'(WINDOW - 1);
                            unlocked <= 1'b1;
                        end else if (i_key_data != KEY0) begin
                            state <= LOCKED;
                        end
                    end
                end
                OPEN: begin
                    if ((LOCK_ON_WRITE && accept) || (count == '0)) begin
                        state    <= LOCKED;
                        count    <= '0;
                        unlocked <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state    <= LOCKED;
                    count    <= '0;
                    unlocked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value     <= INITIAL_VALUE;
            violation <= 1'b0;
        end else begin
            if (accept) begin
                value <= (value & ~wmask) | (wdata & wmask);
            end
            violation <= wr && !accept;
        end
    end

    assign register_if.value[MSB:LSB]     = value;
    assign register_if.read_data[MSB:LSB] = value;
    assign o_value     = value;
    assign o_unlocked  = USE_KEY ? unlocked : 1'b1;
    assign o_violation = violation;
endmodule

// File: tb/tb_rggen_bit_field_rwl_rwe_keyed.sv
// Directed bench: three field instances covering lock-on-write,
// timed window and enable-mode gating.
module tb_rggen_bit_field_rwl_rwe_keyed;
    import rggen_rtl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       le_a = 1'b0, le_b = 1'b0, le_c = 1'b0;
    logic       kv_a = 1'b0, kv_b = 1'b0, kv_c = 1'b0;
    logic [7:0] kd_a = '0, kd_b = '0, kd_c = '0;
    logic [7:0] val_a, val_b, val_c;
    logic       un_a, un_b, un_c;
    logic       vi_a, vi_b, vi_c;
    int         total = 0;
    int         bad = 0;
    int         hi = 0;

    always #5 clk = ~clk;

    rggen_register_if #(.DATA_WIDTH(8)) rif_a ();
    rggen_register_if #(.DATA_WIDTH(8)) rif_b ();
    rggen_register_if #(.DATA_WIDTH(8)) rif_c ();

    rggen_bit_field_rwl_rwe_keyed #(
        .MODE(RGGEN_LOCK_MODE), .MSB(7), .LSB(0),
        .INITIAL_VALUE(8'h3C), .USE_KEY(1'b1), .KEY_WIDTH(8),
        .KEY0(8'h5A), .KEY1(8'hA5), .WINDOW(16), .LOCK_ON_WRITE(1'b1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .i_lock_or_enable(le_a),
        .i_key_valid(kv_a), .i_key_data(kd_a), .register_if(rif_a),
        .o_value(val_a), .o_unlocked(un_a), .o_violation(vi_a)
    );

    rggen_bit_field_rwl_rwe_keyed #(
        .MODE(RGGEN_LOCK_MODE), .MSB(7), .LSB(0),
        .INITIAL_VALUE(8'h3C), .USE_KEY(1'b1), .KEY_WIDTH(8),
        .KEY0(8'h5A), .KEY1(8'hA5), .WINDOW(4), .LOCK_ON_WRITE(1'b0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .i_lock_or_enable(le_b),
        .i_key_valid(kv_b), .i_key_data(kd_b), .register_if(rif_b),
        .o_value(val_b), .o_unlocked(un_b), .o_violation(vi_b)
    );

    rggen_bit_field_rwl_rwe_keyed #(
        .MODE(RGGEN_ENABLE_MODE), .MSB(7), .LSB(0),
        .INITIAL_VALUE(8'h3C), .USE_KEY(1'b1), .KEY_WIDTH(8),
        .KEY0(8'h5A), .KEY1(8'hA5), .WINDOW(16), .LOCK_ON_WRITE(1'b1)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .i_lock_or_enable(le_c),
        .i_key_valid(kv_c), .i_key_data(kd_c), .register_if(rif_c),
        .o_value(val_c), .o_unlocked(un_c), .o_violation(vi_c)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int u, input logic [7:0] d,
                          input logic [7:0] m);
        case (u)
            0: begin
                rif_a.valid = 1'b1; rif_a.write = 1'b1;
                rif_a.write_data = d; rif_a.write_mask = m;
            end
            1: begin
                rif_b.valid = 1'b1; rif_b.write = 1'b1;
                rif_b.write_data = d; rif_b.write_mask = m;
            end
            default: begin
                rif_c.valid = 1'b1; rif_c.write = 1'b1;
                rif_c.write_data = d; rif_c.write_mask = m;
            end
        endcase
    endtask

    task automatic set_key(input int u, input logic [7:0] k);
        case (u)
            0: begin kv_a = 1'b1; kd_a = k; end
            1: begin kv_b = 1'b1; kd_b = k; end
            default: begin kv_c = 1'b1; kd_c = k; end
        endcase
    endtask

    task automatic clr();
        rif_a.valid = 1'b0; rif_a.write = 1'b0;
        rif_b.valid = 1'b0; rif_b.write = 1'b0;
        rif_c.valid = 1'b0; rif_c.write = 1'b0;
        kv_a = 1'b0; kv_b = 1'b0; kv_c = 1'b0;
    endtask

    task automatic step_wr(input int u, input logic [7:0] d,
                           input logic [7:0] m);
        set_wr(u, d, m);
        cyc();
        clr();
    endtask

    task automatic step_key(input int u, input logic [7:0] k);
        set_key(u, k);
        cyc();
        clr();
    endtask

    initial begin
        rif_a.write_data = '0; rif_a.write_mask = '0;
        rif_b.write_data = '0; rif_b.write_mask = '0;
        rif_c.write_data = '0; rif_c.write_mask = '0;
        clr();
        repeat (2) cyc();
        rst_n = 1'b1;

        check("rst_value", val_a, 8'h3C);
        check("rst_read_data", rif_a.read_data, 8'h3C);
        check("rst_unlocked", {7'd0, un_a}, 8'h00);
        check("rst_violation", {7'd0, vi_a}, 8'h00);

        step_wr(0, 8'hFF, 8'hFF);
        check("locked_wr_viol", {7'd0, vi_a}, 8'h01);
        check("locked_wr_value", val_a, 8'h3C);
        cyc();
        check("viol_one_cycle", {7'd0, vi_a}, 8'h00);

        step_key(0, 8'h5A);
        check("key0_not_open", {7'd0, un_a}, 8'h00);
        step_key(0, 8'hA5);
        check("key1_open", {7'd0, un_a}, 8'h01);
        step_wr(0, 8'h81, 8'hFF);
        check("open_wr_value", val_a, 8'h81);
        check("open_wr_regif", rif_a.value, 8'h81);
        check("relock_on_wr", {7'd0, un_a}, 8'h00);
        check("open_wr_no_viol", {7'd0, vi_a}, 8'h00);
        step_wr(0, 8'h00, 8'hFF);
        check("relocked_viol", {7'd0, vi_a}, 8'h01);
        check("relocked_value", val_a, 8'h81);

        step_key(0, 8'h5A);
        set_key(0, 8'hA5);
        set_wr(0, 8'h77, 8'hFF);
        cyc();
        clr();
        check("wr_with_key1_viol", {7'd0, vi_a}, 8'h01);
        check("wr_with_key1_value", val_a, 8'h81);
        check("wr_with_key1_open", {7'd0, un_a}, 8'h01);
        step_wr(0, 8'h00, 8'h00);
        check("zero_mask_no_viol", {7'd0, vi_a}, 8'h00);
        check("zero_mask_closes", {7'd0, un_a}, 8'h00);
        check("zero_mask_value", val_a, 8'h81);

        step_key(0, 8'h5A);
        step_key(0, 8'h33);
        step_key(0, 8'hA5);
        check("bad_seq_locked", {7'd0, un_a}, 8'h00);
        step_wr(0, 8'h11, 8'hFF);
        check("bad_seq_viol", {7'd0, vi_a}, 8'h01);
        check("bad_seq_value", val_a, 8'h81);

        step_key(1, 8'h5A);
        step_key(1, 8'hA5);
        hi += int'(un_b);
        step_wr(1, 8'h01, 8'hFF);
        hi += int'(un_b);
        check("win_c1_value", val_b, 8'h01);
        check("win_c1_no_viol", {7'd0, vi_b}, 8'h00);
        cyc();
        hi += int'(un_b);
        cyc();
        hi += int'(un_b);
        step_wr(1, 8'h04, 8'hFF);
        hi += int'(un_b);
        check("win_c4_value", val_b, 8'h04);
        check("win_c4_no_viol", {7'd0, vi_b}, 8'h00);
        step_wr(1, 8'h05, 8'hFF);
        hi += int'(un_b);
        check("win_c5_viol", {7'd0, vi_b}, 8'h01);
        check("win_c5_value", val_b, 8'h04);
        check("win_open_cycles", 8'(hi), 8'd4);

        step_key(2, 8'h5A);
        step_key(2, 8'hA5);
        check("en_open", {7'd0, un_c}, 8'h01);
        step_wr(2, 8'hAA, 8'h0F);
        check("en_gate_viol", {7'd0, vi_c}, 8'h01);
        check("en_gate_value", val_c, 8'h3C);
        check("en_gate_still_open", {7'd0, un_c}, 8'h01);
        le_c = 1'b1;
        step_wr(2, 8'hAA, 8'h0F);
        check("en_merge_value", val_c, 8'h3A);
        check("en_merge_no_viol", {7'd0, vi_c}, 8'h00);

        step_key(1, 8'h5A);
        step_key(1, 8'hA5);
        step_wr(1, 8'h55, 8'hFF);
        check("pre_rst_value", val_b, 8'h55);
        check("pre_rst_open", {7'd0, un_b}, 8'h01);
        le_b = 1'b1;
        step_wr(1, 8'h66, 8'hFF);
        check("pre_rst_viol", {7'd0, vi_b}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_value", val_b, 8'h3C);
        check("mid_rst_unlocked", {7'd0, un_b}, 8'h00);
        check("mid_rst_viol", {7'd0, vi_b}, 8'h00);
        #2;
        rst_n = 1'b1;
        le_b = 1'b0;
        cyc();
        step_wr(1, 8'h77, 8'hFF);
        check("post_rst_viol", {7'd0, vi_b}, 8'h01);
        check("post_rst_value", val_b, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rggen_bit_field_rwl_rwe_keyed.md
# rggen_bit_field_rwl_rwe_keyed

Key-protected lock/enable bit field for rggen-generated register blocks. Like a plain lock/enable field, software writes take effect only while an external lock/enable condition permits them. This block adds a two-word unlock key sequence that opens a bounded write window, with optional auto-relock after one accepted write. It also reports rejected write attempts. It sits inside a register, driving its slice of the register's `register_if`.

## Interface
Parameters:
- `MODE`, `RGGEN_LOCK_MODE`: gating polarity.
  - `RGGEN_LOCK_MODE`: writable while `i_lock_or_enable`=0.
  - `RGGEN_ENABLE_MODE`: writable while `i_lock_or_enable`=1.
- `MSB`, 0: field MSB within the register.
- `LSB`, 0: field LSB within the register.
- `INITIAL_VALUE`, '0: reset value, width MSB-LSB+1.
- `USE_KEY`, 1: 1 = key sequence required; 0 = window permanently open (gating by `i_lock_or_enable` only).
- `KEY_WIDTH`, 8: key word width.
- `KEY0`, 'h5A: first key word.
- `KEY1`, 'hA5: second key word.
- `WINDOW`, 16: number of cycles the window stays open, ≥1.
- `LOCK_ON_WRITE`, 1: 1 = window closes after the first accepted write.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `i_lock_or_enable` in 1: external lock/enable condition.
- `i_key_valid` in 1: key word strobe, one word per cycle.
- `i_key_data` in KEY_WIDTH: key word.
- `register_if` (`rggen_register_if.data`): drives `value[MSB:LSB]` and `read_data[MSB:LSB]`; consumes `write_access()`, `write_data`, and `write_mask`.
- `o_value` out MSB-LSB+1: field value.
- `o_unlocked` out 1: high while the state is OPEN.
- `o_violation` out 1: one-cycle pulse per rejected write.

## Operation
- State machine (`USE_KEY`=1): LOCKED, KEY0_SEEN, OPEN. Reset state is LOCKED.
- LOCKED:
  - `i_key_valid` with `i_key_data`==KEY0 -> KEY0_SEEN.
  - Any other key word -> stay LOCKED.
- KEY0_SEEN:
  - Valid KEY1 -> OPEN; load the window counter with WINDOW-1.
  - Valid KEY0 -> stay KEY0_SEEN.
  - Any other valid word -> LOCKED.
  - No valid word -> hold, with no timeout.
- OPEN:
  - Counter==0 -> LOCKED.
  - Otherwise the counter decrements every cycle.
  - If LOCK_ON_WRITE=1, an accepted write -> LOCKED, with priority over the counter.
  - Key strobes are ignored.
- `USE_KEY`=0: there is no state machine; the block is permanently OPEN and `o_unlocked`=1.
- gate_ok:
  - `!i_lock_or_enable` when MODE=RGGEN_LOCK_MODE.
  - `i_lock_or_enable` when MODE=RGGEN_ENABLE_MODE.
- A write is accepted when `write_access()` && gate_ok && state==OPEN. On acceptance: value <= (value & ~mask) | (wdata & mask) over bits [MSB:LSB].
- A write is rejected when `write_access()` is true but the write is not accepted. Value is unchanged and `o_violation` pulses.
- Reads are never gated: `read_data[MSB:LSB]` = value.
- The counter width is $clog2(WINDOW+1). It never underflows.

## Timing
- Reset values: value=INITIAL_VALUE, state=LOCKED, counter=0, `o_unlocked`=0 (1 if `USE_KEY`=0), `o_violation`=0.
- `o_value`, `register_if.value`, and `read_data` update the cycle after an accepted write.
- Key-to-window latency:
  - The KEY1 sample at edge N puts the state in OPEN from cycle N+1.
  - Writes are accepted in cycles N+1 .. N+WINDOW, inclusive.
  - `o_unlocked` is registered and goes high in cycle N+1.
- A write in the same cycle as the KEY1 strobe is rejected, because the state is not yet OPEN.
- A write in the last window cycle (counter==0) is accepted. The state is LOCKED the next cycle.
- gate_ok low during OPEN: the write is rejected and flagged as a violation. The window keeps counting down and is not extended.
- LOCK_ON_WRITE=1 with a write whose mask is all-zero: the write still counts as accepted and closes the window.
- `o_violation` is registered: high for exactly one cycle, the cycle after the rejected write.
- Asserting `rst_n` mid-window returns the block to LOCKED immediately. Value returns to INITIAL_VALUE and any pending violation pulse is cleared.

## Test plan
- Reset, then a write of 'hFF with full mask while LOCKED and gate_ok (MSB=7, LSB=0, INITIAL_VALUE='h3C) -> value stays 'h3C; `o_violation` pulses once.
- Key sequence 'h5A then 'hA5, then a write of 'h81 one cycle later -> value='h81 the next cycle. With LOCK_ON_WRITE=1, `o_unlocked` drops the cycle after that write, and a second write of 'h00 is rejected.
- Key sequence 'h5A, 'h33, 'hA5 -> state stays LOCKED (`o_unlocked`=0); a write of 'h11 is rejected.
- LOCK_ON_WRITE=0, WINDOW=4, after a valid key:
  - Writes in window cycles 1 and 4 are accepted.
  - A write in cycle 5 is rejected.
  - `o_unlocked` is high for exactly 4 cycles.
- MODE=RGGEN_ENABLE_MODE, window open, `i_lock_or_enable`=0 -> a write with write_mask='h0F is rejected. Then `i_lock_or_enable`=1 -> a write_data of 'hAA merges to (old & 'hF0) | 'h0A.
- `rst_n` pulsed low during OPEN after value was written to 'h55 -> value='h3C, `o_unlocked`=0, `o_violation`=0. A write after reset without a key is rejected.
